// File: rtl/k_picker_arb.sv
// Round-robin front end sharing one base-2 range-reduction picker among NREQ requesters.
// Credit-reserved response FIFO absorbs the non-stallable picker output.

module base2_k_picker #(
  parameter int unsigned DW       = 16,
  parameter int          K_MIN    = -16,
  parameter int          K_MAX    = 16,
  parameter int unsigned PICK_LAT = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          valid_i,
  input  logic [DW-1:0] t_i,
  output logic          valid_o,
  output logic [7:0]    k_o,
  output logic [DW-1:0] k_fp16_o,
  output logic [DW-1:0] f_o
);
  localparam logic signed [17:0] KMIN = 18'(K_MIN);
  localparam logic signed [17:0] KMAX = 18'(K_MAX);

  typedef struct packed {
    logic [7:0]    k;
    logic [DW-1:0] kfp;
    logic [DW-1:0] f;
  } pres_t;

  // Magnitude in units of 2^-24 to FP16 with round-to-nearest-even.
  function automatic logic [15:0] to_fp16(input logic sgn, input logic [41:0] mag);
    int          p;
    logic [9:0]  m10;
    logic        g;
    logic        st;
    logic [14:0] em;
    p = -1;
    for (int i = 0; i < 42; i++) if (mag[i]) p = i;
    if (p < 10) begin
      em = {5'd0, mag[9:0]};
    end else begin
      m10 = 10'(mag >> 6'(p - 10));
      g   = 1'(mag >> 6'(p - 11));
      st  = (mag & ((42'd1 << 6'(p - 11)) - 42'd1)) != '0;
      em  = {5'(p - 9), m10} + 15'(g & (st | m10[0]));
    end
    return {sgn, em};
  endfunction

  logic              sgn;
  logic [4:0]        ex;
  logic [10:0]       mant;
  logic [41:0]       mag;
  logic signed [41:0] tfix, ffix, fneg;
  logic signed [17:0] kraw, kv, kneg, kabs;
  pres_t             res_c;
  logic              vpipe [PICK_LAT];
  pres_t             dpipe [PICK_LAT];

  // t -> fixed point, floor, saturate, subtract, back to FP16
  always_comb begin
    sgn  = t_i[15];
    ex   = t_i[14:10];
    mant = {ex != 5'd0, t_i[9:0]};
    mag  = 42'(mant) << ((ex == 5'd0) ? 5'd0 : ex - 5'd1);
    tfix = sgn ? (42'sd0 - $signed(mag)) : $signed(mag);
    kraw = tfix[41:24];
    if (ex == 5'h1f)      kv = sgn ? KMIN : KMAX;
    else if (kraw < KMIN) kv = KMIN;
    else if (kraw > KMAX) kv = KMAX;
    else                  kv = kraw;
    ffix = tfix - $signed({kv, 24'd0});
    fneg = 42'sd0 - ffix;
    kneg = 18'sd0 - kv;
    kabs = kv[17] ? kneg : kv;
    res_c.k   = kv[7:0];
    res_c.kfp = to_fp16(kv[17], {kabs, 24'd0});
    res_c.f   = (ex == 5'h1f) ? t_i : to_fp16(ffix[41], ffix[41] ? fneg : ffix);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(PICK_LAT); i++) begin
        vpipe[i] <= 1'b0;
        dpipe[i] <= '0;
      end
    end else begin
      vpipe[0] <= valid_i;
      dpipe[0] <= res_c;
      for (int i = 1; i < int'(PICK_LAT); i++) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
    end
  end

  assign valid_o  = vpipe[PICK_LAT-1];
  assign k_o      = dpipe[PICK_LAT-1].k;
  assign k_fp16_o = dpipe[PICK_LAT-1].kfp;
  assign f_o      = dpipe[PICK_LAT-1].f;
endmodule

module k_picker_arb #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DW         = 16,
  parameter int          K_MIN      = -16,
  parameter int          K_MAX      = 16,
  parameter int unsigned PICK_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*DW-1:0]            req_t,
  output logic [NREQ-1:0]               req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [7:0]                    rsp_k,
  output logic [DW-1:0]                 rsp_k_fp16,
  output logic [DW-1:0]                 rsp_f,
  output logic [$clog2(PICK_LAT+1):0]   inflight_o
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned IFW = $clog2(PICK_LAT + 1) + 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     k;
    logic [DW-1:0]  kfp;
    logic [DW-1:0]  f;
  } rsp_t;

  logic [IDW-1:0] rr_ptr, gnt_id;
  logic           gnt_found, credit_ok, issue, push, pop;
  logic [IFW-1:0] inflight;
  logic [CW-1:0]  fifo_count;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  rsp_t           mem [FIFO_DEPTH];
  logic           tag_vld [PICK_LAT];
  logic [IDW-1:0] tag_id  [PICK_LAT];
  logic [DW-1:0]  t_last, pick_t;
  logic           pick_vo;
  logic [7:0]     pick_k;
  logic [DW-1:0]  pick_kfp, pick_f;
  int unsigned    idx;

  // Round-robin scan from rr_ptr, gated by FIFO credit
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
    credit_ok = (32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH;
    issue     = !rst && gnt_found && credit_ok;
    req_ready = issue ? (NREQ'(1) << gnt_id) : '0;
    pick_t    = issue ? req_t[int'(gnt_id)*DW +: DW] : t_last;
  end

  base2_k_picker #(.DW(DW), .K_MIN(K_MIN), .K_MAX(K_MAX), .PICK_LAT(PICK_LAT)) u_picker (
    .clk      (clk),
    .rstn     (~rst),
    .valid_i  (issue),
    .t_i      (pick_t),
    .valid_o  (pick_vo),
    .k_o      (pick_k),
    .k_fp16_o (pick_kfp),
    .f_o      (pick_f)
  );

  assign push = pick_vo;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      t_last     <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      for (int i = 0; i < int'(PICK_LAT); i++) begin
        tag_vld[i] <= 1'b0;
        tag_id[i]  <= '0;
      end
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : IDW'(gnt_id + 1'b1);
        t_last <= pick_t;
      end
      tag_vld[0] <= issue;
      tag_id[0]  <= issue ? gnt_id : '0;
      for (int i = 1; i < int'(PICK_LAT); i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      if (issue && !push)      inflight <= IFW'(inflight + 1'b1);
      else if (!issue && push) inflight <= IFW'(inflight - 1'b1);
      if (push) begin
        mem[wr_ptr] <= '{id: tag_id[PICK_LAT-1], k: pick_k, kfp: pick_kfp, f: pick_f};
        wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : PW'(wr_ptr + 1'b1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : PW'(rd_ptr + 1'b1);
      if (push && !pop)      fifo_count <= CW'(fifo_count + 1'b1);
      else if (pop && !push) fifo_count <= CW'(fifo_count - 1'b1);
    end
  end

  assign rsp_valid  = fifo_count != '0;
  assign rsp_id     = mem[rd_ptr].id;
  assign rsp_k      = mem[rd_ptr].k;
  assign rsp_k_fp16 = mem[rd_ptr].kfp;
  assign rsp_f      = mem[rd_ptr].f;
  assign inflight_o = inflight;

  a_tag_sync: assert property (@(posedge clk) disable iff (rst) pick_vo |-> tag_vld[PICK_LAT-1])
    else $error("picker result without matching tag");
  a_no_ovf: assert property (@(posedge clk) disable iff (rst) push |-> (fifo_count != CW'(FIFO_DEPTH)))
    else $error("response FIFO overflow");
endmodule

// File: tb/tb_k_picker_arb.sv
// Directed bench for k_picker_arb: grant order, latency, credit backpressure, ordering, reset.

module tb_k_picker_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_t = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_k;
  logic [15:0] rsp_k_fp16, rsp_f;
  logic [2:0]  inflight_o;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  k_picker_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_t(req_t), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_k(rsp_k),
    .rsp_k_fp16(rsp_k_fp16), .rsp_f(rsp_f), .inflight_o(inflight_o)
  );

  function automatic int oh2id(input logic [3:0] oh);
    int r = -1;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at posedge+1 of the first cycle after reset release.
  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    req_t = 64'h4200_4000_3C00_3E00;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%h exp=0", rsp_id); end
    checks++; if (rsp_k !== 8'd0) begin failures++; $display("FAIL reset_rsp_k got=%h exp=0", rsp_k); end
    checks++; if (rsp_k_fp16 !== 16'd0) begin failures++; $display("FAIL reset_rsp_k_fp16 got=%h exp=0", rsp_k_fp16); end
    checks++; if (rsp_f !== 16'd0) begin failures++; $display("FAIL reset_rsp_f got=%h exp=0", rsp_f); end
    checks++; if (inflight_o !== 3'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight_o); end
    req_valid = '0;
  endtask

  task automatic test_single();
    int early = 0;
    do_reset();
    req_valid = 4'b0100;
    req_t = 64'h0000_3E00_0000_0000;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    for (int c = 1; c <= 4; c++) begin
      step();
      req_valid = '0;
      #1;
      if (c == 1) begin
        checks++; if (inflight_o !== 3'd1) begin failures++; $display("FAIL single_inflight got=%0d exp=1", inflight_o); end
      end
      if (c < 4 && rsp_valid) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL single_early_rsp got=%0d exp=0", early); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
    checks++; if (rsp_k !== 8'd1) begin failures++; $display("FAIL single_k got=%h exp=01", rsp_k); end
    checks++; if (rsp_k_fp16 !== 16'h3C00) begin failures++; $display("FAIL single_k_fp16 got=%h exp=3c00", rsp_k_fp16); end
    checks++; if (rsp_f !== 16'h3800) begin failures++; $display("FAIL single_f got=%h exp=3800", rsp_f); end
    checks++; if (inflight_o !== 3'd0) begin failures++; $display("FAIL single_inflight_done got=%0d exp=0", inflight_o); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0]  ek [4];
    logic [15:0] ekf [4];
    logic [15:0] ef [4];
    logic [3:0]  mask = 4'hF;
    int n = 0;
    ek  = '{8'h01, 8'hFE, 8'h10, 8'h00};
    ekf = '{16'h3C00, 16'hC000, 16'h4C00, 16'h0000};
    ef  = '{16'h3800, 16'h3800, 16'h5540, 16'h0000};
    do_reset();
    rsp_ready = 1'b1;
    req_t = 64'h0000_5640_BE00_3E00;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      req_valid = mask;
      #1;
      if (c < 4) begin
        checks++;
        if (req_ready !== (4'b0001 << c)) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", c, req_ready, 4'b0001 << c); end
        mask = mask & ~req_ready;
      end
      if (rsp_valid && n < 4) begin
        checks++; if (rsp_id !== 2'(n)) begin failures++; $display("FAIL rr_id%0d got=%0d exp=%0d", n, rsp_id, n); end
        checks++; if (rsp_k !== ek[n]) begin failures++; $display("FAIL rr_k%0d got=%h exp=%h", n, rsp_k, ek[n]); end
        checks++; if (rsp_k_fp16 !== ekf[n]) begin failures++; $display("FAIL rr_kfp%0d got=%h exp=%h", n, rsp_k_fp16, ekf[n]); end
        checks++; if (rsp_f !== ef[n]) begin failures++; $display("FAIL rr_f%0d got=%h exp=%h", n, rsp_f, ef[n]); end
        n++;
      end else if (rsp_valid) n++;
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL rr_rsp_count got=%0d exp=4", n); end
    req_valid = '0;
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wrap_setup got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL wrap_first got=%b exp=1000", req_ready); end
    step();
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wrap_second got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int grants = 0;
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      #1;
      if (req_ready[0]) grants++;
    end
    checks++; if (grants !== 8) begin failures++; $display("FAIL bp_grants got=%0d exp=8", grants); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_stalled got=%b exp=0000", req_ready); end
    step();
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_head_valid got=%b exp=1", rsp_valid); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_pop_cycle got=%b exp=0000", req_ready); end
    step();
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_regrant got=%b exp=0001", req_ready); end
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      #1;
      if (req_ready[0]) grants++;
    end
    checks++; if (grants !== 0) begin failures++; $display("FAIL bp_extra_grants got=%0d exp=0", grants); end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    int q[$];
    int issued = 0, issued_at_31 = 0, nrsp = 0, bad = 0, cnt_bad = 0, e;
    do_reset();
    rsp_ready = 1'b1;
    req_t = 64'h4200_4000_3C00_0000;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) step();
      req_valid = (issued < 32) ? 4'hF : 4'h0;
      #1;
      if (req_ready !== 4'h0) begin q.push_back(oh2id(req_ready)); issued++; end
      if (c == 31) issued_at_31 = issued;
      if (rsp_valid) begin
        nrsp++;
        if (q.size() == 0) bad++;
        else begin
          e = q.pop_front();
          if (rsp_id !== 2'(e) || rsp_k !== 8'(e)) bad++;
        end
      end
      if (c >= 5 && c < 32 && dut.fifo_count !== 4'd1) cnt_bad++;
    end
    checks++; if (issued_at_31 !== 32) begin failures++; $display("FAIL b2b_throughput got=%0d exp=32", issued_at_31); end
    checks++; if (nrsp !== 32) begin failures++; $display("FAIL b2b_rsp_count got=%0d exp=32", nrsp); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_order got=%0d bad exp=0", bad); end
    checks++; if (cnt_bad !== 0) begin failures++; $display("FAIL b2b_fifo_count got=%0d off-cycles exp=0", cnt_bad); end
    checks++; if (q.size() !== 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", q.size()); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int grants = 0, stale = 0;
    do_reset();
    req_valid = 4'b0010;
    req_t = 64'h0000_0000_BE00_0000;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      #1;
      if (req_ready === 4'b0010) grants++;
    end
    checks++; if (grants !== 3) begin failures++; $display("FAIL mid_grants got=%0d exp=3", grants); end
    step();
    req_valid = '0;
    step();
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_rst_valid got=%b exp=1", rsp_valid); end
    rst = 1'b1;
    req_valid = 4'b0010;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", rsp_valid); end
    checks++; if (inflight_o !== 3'd0) begin failures++; $display("FAIL mid_rst_inflight got=%0d exp=0", inflight_o); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    checks++; if ({rsp_id, rsp_k, rsp_k_fp16, rsp_f} !== 42'd0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", {rsp_id, rsp_k, rsp_k_fp16, rsp_f}); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready); end
    for (int c = 1; c <= 4; c++) begin
      step();
      req_valid = '0;
      #1;
      if (c < 4 && rsp_valid) stale++;
    end
    checks++; if (stale !== 0) begin failures++; $display("FAIL mid_stale got=%0d exp=0", stale); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_new_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL mid_new_id got=%0d exp=1", rsp_id); end
    checks++; if (rsp_k !== 8'hFE) begin failures++; $display("FAIL mid_new_k got=%h exp=fe", rsp_k); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
